uart_ascii_rx: RTL
==================

UART_ASCII_RX -- requirements
Module: uart_ascii_rx

Interface
REQ-001: Parameter p_clks_per_bit, default 434, SHALL be the clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002: Parameter p_filter, default 1, SHALL enable forwarding only of displayable codes when 1, and of all codes when 0.
REQ-003: clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005: rx  input  1  asynchronous UART serial line; idle high; 8N1 format, LSB first.
REQ-006: ascii  output  8  last accepted character; feeds the character display's ascii input.
REQ-007: ascii_val  output  1  single-cycle strobe marking a new ascii value.
REQ-008: frame_err  output  1  single-cycle strobe on a stop-bit error.

Function
REQ-009: rx SHALL pass through a 2-flop synchronizer before use; both flops reset to 1; "srx" below means the synchronized value.
REQ-010: The FSM SHALL have exactly five states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011: A bit counter SHALL be $clog2(p_clks_per_bit) bits wide, and a bit index SHALL be 3 bits wide.
REQ-012: In IDLE, srx==0 SHALL clear the counter and move the FSM to START.
REQ-013: In START, at counter == p_clks_per_bit/2 - 1 (integer division), srx SHALL be sampled.
REQ-014: At that START sample, srx==1 SHALL be treated as a glitch and return the FSM to IDLE with no output.
REQ-015: At that START sample, srx==0 SHALL clear the counter and bit index and move the FSM to DATA.
REQ-016: In DATA, at counter == p_clks_per_bit - 1, srx SHALL shift into the MSB of an 8-bit shift register (shift right), the counter SHALL clear, and the bit index SHALL increment.
REQ-017: In DATA, the sample taken with bit index == 7 SHALL move the FSM to STOP.
REQ-018: In STOP, at counter == p_clks_per_bit - 1, srx SHALL be sampled.
REQ-019: At the STOP sample, srx==1 SHALL return the FSM to IDLE and accept the byte if the filter passes.
REQ-020: At the STOP sample, srx==0 SHALL pulse frame_err on the next cycle, discard the byte, and move the FSM to WAIT_HIGH.
REQ-021: WAIT_HIGH SHALL remain until srx==1 and then go to IDLE, so that a break condition is never decoded as characters.
REQ-022: Filter pass SHALL mean p_filter==0, or byte in 0x20..0x7E, or byte in {0x08, 0x0A, 0x0D}.
REQ-023: A filtered-out byte SHALL produce neither ascii_val nor frame_err, and SHALL leave ascii unchanged.
REQ-024: On acceptance, ascii SHALL load the byte and ascii_val SHALL be 1 for exactly one cycle: the cycle after the STOP sample edge.
REQ-025: ascii SHALL hold its value until the next acceptance.
REQ-026: Latency from the rx start-bit falling edge to ascii_val SHALL be 2 (synchronizer) + 1 (IDLE detect) + p_clks_per_bit/2 + 9*p_clks_per_bit + 1 cycles, with ±1 cycle tolerance for edge alignment.
REQ-027: ascii_val and frame_err SHALL never be asserted in the same cycle.
REQ-028: No handshake with the consumer SHALL exist; the consumer must accept one strobe per character time.
REQ-029: A new start bit SHALL be detectable in the cycle immediately after a return to IDLE, so back-to-back frames with no idle gap decode correctly.

Reset
REQ-030: While rst==0, the block SHALL hold: FSM=IDLE, counter=0, bit index=0, shift register=0x00, synchronizer=1,1, ascii=0x00, ascii_val=0, frame_err=0.
REQ-031: Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-032: After rst returns to 1, the block SHALL wait in IDLE for the next falling edge of srx.

Verification (p_clks_per_bit=8 unless stated)
REQ-033: Frame 0x41 ('A') with correct stop bit -> ascii=0x41 with one ascii_val pulse at cycle 2+1+4+72+1 (±1) after the start edge; frame_err stays 0.
REQ-034: Frames 0x48 and 0x69 back-to-back with no idle gap -> two ascii_val pulses 80 cycles apart (±1), with ascii=0x48 then 0x69.
REQ-035: rx low for 2 cycles, then high -> no ascii_val, FSM back in IDLE, and a following 0x5A frame decodes correctly.
REQ-036: Frame 0x33 with stop bit 0 and rx held low for 30 cycles -> one frame_err pulse, no ascii_val, no decode until rx rises.
REQ-037: p_filter=1: frame 0x07 -> no strobe and ascii unchanged; frame 0x0D -> ascii_val with ascii=0x0D. p_filter=0: frame 0x07 -> ascii_val with ascii=0x07.
REQ-038: rst driven low during DATA bit 4 of a frame -> all outputs at their reset values immediately (asynchronously), and no strobe for the aborted frame.

Source files
------------

// File: rtl/uart_ascii_rx.sv
// rtl/uart_ascii_rx.sv - 8N1 UART receiver forwarding displayable ASCII characters
// Mid-bit sampling from a half-bit start check; a low stop bit parks in WAIT_HIGH so a break never decodes.
module uart_ascii_rx #(
    parameter int p_clks_per_bit = 434,
    parameter bit p_filter       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] ascii,
    output logic       ascii_val,
    output logic       frame_err
);

    localparam int lp_cw = $clog2(p_clks_per_bit);
    localparam logic [lp_cw-1:0] lp_half = lp_cw'(p_clks_per_bit / 2 - 1);
    localparam logic [lp_cw-1:0] lp_last = lp_cw'(p_clks_per_bit - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic [lp_cw-1:0]  r_cnt;
    logic [lp_cw-1:0]  w_cnt_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [7:0]        r_ascii;
    logic              r_ascii_val;
    logic              r_frame_err;
    logic              w_accept;
    logic              w_ferr;
    logic              w_pass;
    logic              w_srx;

    assign w_srx = r_sync2;

    // Backspace, line feed and carriage return are let through alongside printable codes.
    assign w_pass = (p_filter == 1'b0)
                 || ((r_shift >= 8'h20) && (r_shift <= 8'h7E))
                 || (r_shift == 8'h08) || (r_shift == 8'h0A) || (r_shift == 8'h0D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_ascii     <= 8'h00;
            r_ascii_val <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_ascii_val <= w_accept;
            r_frame_err <= w_ferr;
            if (w_accept) begin
                r_ascii <= r_shift;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_accept    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_srx) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == lp_half) begin
                    w_cnt_nxt = '0;
                    if (w_srx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == lp_last) begin
                    w_shift_nxt = {w_srx, r_shift[7:1]};
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == lp_last) begin
                    w_cnt_nxt = '0;
                    if (w_srx) begin
                        w_accept    = w_pass;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (w_srx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ascii     = r_ascii;
    assign ascii_val = r_ascii_val;
    assign frame_err = r_frame_err;

endmodule
